// File: rtl/bmu_multicycle.sv
// Iterative Zbb/Zbc bit-manipulation unit: CLMUL, CLMULH, CLMULR, CLZ, CTZ, CPOP.
// Processes STEP operand bits per cycle; one op in flight, result strobed on out_valid.
module bmu_multicycle #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STEP       = 1,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      option,
    input  logic [XLEN-1:0] in_x,
    input  logic [XLEN-1:0] in_y,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result
);

    localparam int unsigned NSTEPS = XLEN / STEP;
    localparam int unsigned CNTW   = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int unsigned CW     = $clog2(XLEN) + 1;

    localparam logic [4:0] OP_CLMUL  = 5'b00001;
    localparam logic [4:0] OP_CLMULH = 5'b00010;
    localparam logic [4:0] OP_CLMULR = 5'b00011;
    localparam logic [4:0] OP_CLZ    = 5'b00100;
    localparam logic [4:0] OP_CPOP   = 5'b00101;
    localparam logic [4:0] OP_CTZ    = 5'b00110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e            state, state_next;
    logic              accept, finish;

    logic [4:0]        op;
    logic [XLEN-1:0]   opd;      // y for CLMUL*, x otherwise; shifted so the current chunk sits at one end
    logic [2*XLEN-1:0] mx;       // x pre-shifted to the current chunk's bit position
    logic [2*XLEN-1:0] prod, prod_next;
    logic [CW-1:0]     acc, acc_next;
    logic              found, found_next;
    logic [CNTW-1:0]   cnt;

    logic              is_clmul, is_clz, is_ctz, is_cpop, is_cnt, known, last, early;
    logic [CW-1:0]     pc, z;
    logic              hit, bitv;
    logic [XLEN-1:0]   result_next;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state, handshake outputs; flush outranks start in every state
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start && !flush) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (flush)       state_next = IDLE;
                else if (finish) state_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                if (start && !flush) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-chunk datapath: carry-less partial product, popcount, leading/trailing zero scan
    always_comb begin
        is_clmul = (op == OP_CLMUL) || (op == OP_CLMULH) || (op == OP_CLMULR);
        is_clz   = (op == OP_CLZ);
        is_ctz   = (op == OP_CTZ);
        is_cpop  = (op == OP_CPOP);
        is_cnt   = is_clz || is_ctz;
        known    = is_clmul || is_cnt || is_cpop;
        last     = (cnt == CNTW'(NSTEPS - 1));

        prod_next = prod;
        for (int unsigned j = 0; j < STEP; j++) begin
            if (opd[j]) prod_next = prod_next ^ (mx << j);
        end

        pc = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            pc = pc + CW'(opd[i]);
        end

        z   = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            bitv = is_clz ? opd[XLEN-1-i] : opd[i];
            if (!hit) begin
                if (bitv) hit = 1'b1;
                else      z   = z + CW'(1);
            end
        end

        acc_next   = acc;
        found_next = found;
        if (is_cpop) begin
            acc_next = acc + pc;
        end else if (is_cnt && !found) begin
            acc_next   = acc + z;
            found_next = hit;
        end

        early  = (EARLY_EXIT != 0) && is_cnt && !found && hit;
        finish = (state == RUN) && (last || early || !known);

        case (op)
            OP_CLMUL:                result_next = prod_next[XLEN-1:0];
            OP_CLMULH:               result_next = prod_next[2*XLEN-1:XLEN];
            OP_CLMULR:               result_next = prod_next[2*XLEN-2:XLEN-1];
            OP_CLZ, OP_CTZ, OP_CPOP: result_next = XLEN'(acc_next);
            default:                 result_next = mx[XLEN-1:0];  // unshifted x while cnt==0
        endcase
    end

    // Operand capture on accept, chunk advance in RUN, result register on the finishing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op         <= '0;
            opd        <= '0;
            mx         <= '0;
            prod       <= '0;
            acc        <= '0;
            found      <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                op    <= option;
                opd   <= ((option == OP_CLMUL) || (option == OP_CLMULH) || (option == OP_CLMULR))
                         ? in_y : in_x;
                mx    <= (2*XLEN)'(in_x);
                prod  <= '0;
                acc   <= '0;
                found <= 1'b0;
                cnt   <= '0;
            end else if (state == RUN && !flush) begin
                cnt   <= cnt + CNTW'(1);
                opd   <= is_clz ? (opd << STEP) : (opd >> STEP);
                mx    <= mx << STEP;
                prod  <= prod_next;
                acc   <= acc_next;
                found <= found_next;
                if (finish) begin
                    out_valid  <= 1'b1;
                    out_result <= result_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bmu_multicycle.sv
// Directed bench for bmu_multicycle: three instances cover STEP=1 with and
// without early exit, and STEP=4.
module tb_bmu_multicycle;

    localparam logic [4:0] OP_CLMUL  = 5'b00001;
    localparam logic [4:0] OP_CLMULH = 5'b00010;
    localparam logic [4:0] OP_CLMULR = 5'b00011;
    localparam logic [4:0] OP_CLZ    = 5'b00100;
    localparam logic [4:0] OP_CPOP   = 5'b00101;
    localparam logic [4:0] OP_CTZ    = 5'b00110;

    logic        clk, rst, flush;
    logic [2:0]  start;
    logic [4:0]  option;
    logic [31:0] in_x, in_y;
    logic        rdy [3];
    logic        bsy [3];
    logic        ov  [3];
    logic [31:0] res [3];

    int total = 0;
    int bad   = 0;

    bmu_multicycle #(.XLEN(32), .STEP(1), .EARLY_EXIT(1)) u_s1_ee (
        .clk(clk), .rst(rst), .start(start[0]), .option(option), .in_x(in_x), .in_y(in_y),
        .flush(flush), .ready(rdy[0]), .busy(bsy[0]), .out_valid(ov[0]), .out_result(res[0]));

    bmu_multicycle #(.XLEN(32), .STEP(1), .EARLY_EXIT(0)) u_s1_full (
        .clk(clk), .rst(rst), .start(start[1]), .option(option), .in_x(in_x), .in_y(in_y),
        .flush(flush), .ready(rdy[1]), .busy(bsy[1]), .out_valid(ov[1]), .out_result(res[1]));

    bmu_multicycle #(.XLEN(32), .STEP(4), .EARLY_EXIT(1)) u_s4 (
        .clk(clk), .rst(rst), .start(start[2]), .option(option), .in_x(in_x), .in_y(in_y),
        .flush(flush), .ready(rdy[2]), .busy(bsy[2]), .out_valid(ov[2]), .out_result(res[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge, then scramble the operand inputs
    task automatic issue(input int sel, input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        option     = op;
        in_x       = x;
        in_y       = y;
        start[sel] = 1'b1;
        @(posedge clk); #1;
        start[sel] = 1'b0;
        option     = 5'b00000;
        in_x       = 32'hDEAD_BEEF;
        in_y       = 32'hCAFE_F00D;
    endtask

    // Edges counted from the accept edge until out_valid; bounded
    task automatic wait_valid(input int sel, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ov[sel] && n < 200);
    endtask

    task automatic run_check(input string tag, input int sel, input logic [4:0] op,
                             input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] exp_res, input int exp_lat);
        int n;
        issue(sel, op, x, y);
        wait_valid(sel, n);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_res"}, res[sel], exp_res);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'd0, ov[sel]}, 32'd0);
    endtask

    initial begin
        int n;
        int strobes;
        int changes;
        logic [31:0] old;

        rst    = 1'b1;
        flush  = 1'b0;
        start  = '0;
        option = '0;
        in_x   = '0;
        in_y   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, rdy[0]}, 32'd1);
        check("rst_busy",  {31'd0, bsy[0]}, 32'd0);
        check("rst_valid", {31'd0, ov[0]},  32'd0);
        check("rst_result", res[0], 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_check("clmul",    0, OP_CLMUL,  32'h3, 32'h5, 32'h0000_000F, 32);
        run_check("clmulh",   0, OP_CLMULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
        run_check("clmulr",   0, OP_CLMULR, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32);
        run_check("clz_ee",   0, OP_CLZ,    32'h0001_0000, 32'h0, 32'd15, 16);
        run_check("clz_full", 1, OP_CLZ,    32'h0001_0000, 32'h0, 32'd15, 32);
        run_check("ctz_zero", 0, OP_CTZ,    32'h0, 32'h0, 32'd32, 32);
        run_check("ctz_ee",   0, OP_CTZ,    32'h0000_0100, 32'h0, 32'd8, 9);
        run_check("cpop4_ff", 2, OP_CPOP,   32'hFFFF_FFFF, 32'h0, 32'd32, 8);
        run_check("cpop4_81", 2, OP_CPOP,   32'h8000_0001, 32'h0, 32'd2, 8);
        run_check("clz4_ee",  2, OP_CLZ,    32'h0001_0000, 32'h0, 32'd15, 4);
        run_check("clmul4",   2, OP_CLMUL,  32'h3, 32'h5, 32'h0000_000F, 8);
        run_check("other_op", 0, 5'b00111,  32'h1234_5678, 32'h0, 32'h1234_5678, 1);

        // Flush in the 10th RUN cycle with start also raised; nothing may follow
        old = res[0];
        issue(0, OP_CPOP, 32'hFFFF_0000, 32'h0);
        check("run_busy",  {31'd0, bsy[0]}, 32'd1);
        check("run_ready", {31'd0, rdy[0]}, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        flush    = 1'b1;
        start[0] = 1'b1;
        option   = OP_CLZ;
        in_x     = 32'h0000_0001;
        @(posedge clk); #1;
        flush    = 1'b0;
        start[0] = 1'b0;
        check("flush_ready",  {31'd0, rdy[0]}, 32'd1);
        check("flush_busy",   {31'd0, bsy[0]}, 32'd0);
        check("flush_valid",  {31'd0, ov[0]},  32'd0);
        check("flush_result", res[0], old);
        strobes = 0;
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov[0]) strobes++;
            if (res[0] !== old) changes++;
        end
        check("flush_strobes", strobes, 0);
        check("flush_hold",    changes, 0);
        run_check("clz_after_flush", 0, OP_CLZ, 32'h0000_0001, 32'h0, 32'd31, 32);

        // Back-to-back: new op accepted in the DONE cycle
        issue(0, OP_CLMUL, 32'h3, 32'h5);
        wait_valid(0, n);
        check("b2b1_lat", n, 32);
        check("b2b1_res", res[0], 32'h0000_000F);
        issue(0, OP_CPOP, 32'hF0F0_0001, 32'h0);
        check("b2b_busy",  {31'd0, bsy[0]}, 32'd1);
        check("b2b_valid", {31'd0, ov[0]},  32'd0);
        wait_valid(0, n);
        check("b2b2_lat", n, 32);
        check("b2b2_res", res[0], 32'd9);

        // Asynchronous reset mid-run
        @(posedge clk); #1;
        issue(0, OP_CLMUL, 32'h3, 32'h5);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready",  {31'd0, rdy[0]}, 32'd1);
        check("arst_busy",   {31'd0, bsy[0]}, 32'd0);
        check("arst_valid",  {31'd0, ov[0]},  32'd0);
        check("arst_result", res[0], 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov[0]) strobes++;
        end
        check("arst_strobes", strobes, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
